// File: rtl/pcg_share_ctrl_if.sv
// Requester-side bus of pcg_share_ctrl: level requests in, one-hot grant
// plus the granted random word out.
interface pcg_share_ctrl_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 64
);
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [DATA_W-1:0] rnd_out;
    logic              rnd_valid;

    // requester side
    modport master (output req, input gnt, input rnd_out, input rnd_valid);
    // controller side
    modport slave  (input req, output gnt, output rnd_out, output rnd_valid);
endinterface

// File: rtl/pcg_share_ctrl.sv
// pcg_share_ctrl: owns one PCG core, handles (re)seeding and flushing, and
// shares the core's word stream round-robin between N_REQ requesters so that
// every delivered word is unique (one core word per cycle, one grant max).
module pcg_share_ctrl #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned PIPE_LAT     = 2,
    parameter int unsigned WARMUP       = 4,
    parameter logic [63:0] SEED_DEFAULT = 64'h853C_49E6_748F_EA9B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       seed_in,
    input  logic              seed_load,
    output logic              core_rst,
    output logic [63:0]       core_seed,
    input  logic [DATA_W-1:0] core_data,
    output logic              busy,
    pcg_share_ctrl_if.slave   bus
);

    localparam int unsigned PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned FLUSH_LEN = PIPE_LAT + WARMUP;
    localparam int unsigned CNT_W     = $clog2(FLUSH_LEN + 2);

    localparam logic [1:0] ST_CORE_RST = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_SERVE    = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              core_rst_q, core_rst_d;
    logic [63:0]       seed_q,     seed_d;
    logic [PTR_W-1:0]  ptr_q,      ptr_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [DATA_W-1:0] rnd_q,      rnd_d;
    logic              vld_q,      vld_d;

    logic              found;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  cand;

    assign core_rst      = core_rst_q;
    assign core_seed     = seed_q;
    assign busy          = (state_q != ST_SERVE);
    assign bus.gnt       = gnt_q;
    assign bus.rnd_out   = rnd_q;
    assign bus.rnd_valid = vld_q;

    // Round-robin pick: first asserted request at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Sequencer: core reset -> flush -> serve; seed_load overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_rst_d = core_rst_q;
        seed_d     = seed_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        rnd_d      = '0;
        vld_d      = 1'b0;

        case (state_q)
            ST_CORE_RST: begin
                core_rst_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_FLUSH;
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SERVE: begin
                if (found) begin
                    gnt_d[sel] = 1'b1;
                    rnd_d      = core_data;
                    vld_d      = 1'b1;
                    ptr_d      = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                end
            end
            default: begin
                state_d    = ST_CORE_RST;
                cnt_d      = '0;
                core_rst_d = 1'b0;
            end
        endcase

        // A reseed cancels any grant computed this cycle; pointer is kept.
        if (seed_load) begin
            seed_d     = seed_in;
            state_d    = ST_CORE_RST;
            cnt_d      = '0;
            core_rst_d = 1'b0;
            ptr_d      = ptr_q;
            gnt_d      = '0;
            rnd_d      = '0;
            vld_d      = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CORE_RST;
            cnt_q      <= '0;
            core_rst_q <= 1'b0;
            seed_q     <= SEED_DEFAULT;
            ptr_q      <= '0;
            gnt_q      <= '0;
            rnd_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_rst_q <= core_rst_d;
            seed_q     <= seed_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rnd_q      <= rnd_d;
            vld_q      <= vld_d;
        end
    end

endmodule

// File: tb/tb_pcg_share_ctrl.sv
// Self-checking bench for pcg_share_ctrl (N_REQ=4, PIPE_LAT=2, WARMUP=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_pcg_share_ctrl;

    localparam logic [63:0] SEED_DEF = 64'h853C_49E6_748F_EA9B;

    logic        clk;
    logic        rst;
    logic [63:0] seed_in;
    logic        seed_load;
    logic        core_rst;
    logic [63:0] core_seed;
    logic [63:0] core_data;
    logic        busy;

    pcg_share_ctrl_if #(.N_REQ(4), .DATA_W(64)) bus ();

    pcg_share_ctrl #(
        .N_REQ(4), .DATA_W(64), .PIPE_LAT(2), .WARMUP(4), .SEED_DEFAULT(SEED_DEF)
    ) dut (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
        .core_rst(core_rst), .core_seed(core_seed), .core_data(core_data),
        .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          blk    = 0;   // remaining busy cycles predicted by the bench
    int          ptr_m  = 0;   // bench's round-robin pointer
    logic [63:0] seed_m = SEED_DEF;
    logic [3:0]  exp_g_q[$];
    logic [63:0] exp_d_q[$];

    // Drive one cycle of stimulus and push the word it must produce, if any.
    task automatic drive(input logic [3:0] r, input logic sl, input logic [63:0] s);
        logic [3:0] oh;
        logic       hit;
        int         idx;
        bus.req   = r;
        seed_load = sl;
        seed_in   = s;
        core_data = {$urandom, $urandom};
        hit       = 1'b0;
        if (sl) begin
            blk    = 8;
            seed_m = s;
        end else if (blk > 0) begin
            blk--;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (ptr_m + k) % 4;
                oh  = 4'b0001 << idx;
                if (!hit && (r & oh) != 4'b0000) begin
                    hit = 1'b1;
                    exp_g_q.push_back(oh);
                    exp_d_q.push_back(core_data);
                    ptr_m = (idx + 1) % 4;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0; seed_load = 1'b0; seed_in = '0; core_data = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (core_rst !== 1'b0 || busy !== 1'b1 || bus.rnd_valid !== 1'b0 ||
            bus.gnt !== 4'b0 || bus.rnd_out !== 64'h0 || core_seed !== SEED_DEF) begin
            n_fail++;
            $display("FAIL reset_values: core_rst=%b busy=%b valid=%b gnt=%b rnd=%h seed=%h, required 0 1 0 0000 0 %h",
                     core_rst, busy, bus.rnd_valid, bus.gnt, bus.rnd_out, core_seed, SEED_DEF);
        end
        rst    = 1'b1;
        blk    = 8;
        ptr_m  = 0;
        seed_m = SEED_DEF;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (busy !== (i < 8) || core_rst !== (i >= 2) || core_seed !== SEED_DEF) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: busy=%b core_rst=%b seed=%h, required busy=%b core_rst=%b seed=%h",
                         i, busy, core_rst, core_seed, (i < 8), (i >= 2), SEED_DEF);
            end
            drive(4'b0000, 1'b0, 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  eg;
        logic [63:0] ed;
        logic [3:0]  want;
        for (int i = 0; i < 9; i++) begin
            if (exp_g_q.size() != 0) begin
                eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
                n_chk++;
                if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
                    n_fail++;
                    $display("FAIL rr_word: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                             bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
                end
                want = 4'b0001 << ((i - 1) % 4);
                n_chk++;
                if (bus.gnt !== want) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, bus.gnt, want);
                end
            end else begin
                n_chk++;
                if (bus.rnd_valid !== 1'b0 || bus.gnt !== 4'b0) begin
                    n_fail++;
                    $display("FAIL rr_idle: valid=%b gnt=%b, required 0 0000", bus.rnd_valid, bus.gnt);
                end
            end
            drive(4'b1111, 1'b0, 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_single_and_wrap();
        logic [3:0]  eg;
        logic [63:0] ed;
        logic [3:0]  reqs [6];
        logic [3:0]  gnts [5];
        reqs = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0000};
        gnts = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            if (exp_g_q.size() != 0) begin
                eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
                n_chk++;
                if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
                    n_fail++;
                    $display("FAIL wrap_word: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                             bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
                end
            end
            if (i >= 1) begin
                n_chk++;
                if (bus.gnt !== gnts[i-1]) begin
                    n_fail++;
                    $display("FAIL wrap_gnt[%0d]: gnt=%b, required %b", i, bus.gnt, gnts[i-1]);
                end
            end
            drive(reqs[i], 1'b0, 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_reseed_during_req();
        logic [3:0]  eg;
        logic [63:0] ed;
        int          rise = -1;
        int          first_v = -1;
        for (int j = 0; j < 12; j++) begin
            if (exp_g_q.size() != 0) begin
                eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
                n_chk++;
                if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
                    n_fail++;
                    $display("FAIL reseed_word: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                             bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
                end
            end else begin
                n_chk++;
                if (bus.rnd_valid !== 1'b0 || bus.gnt !== 4'b0) begin
                    n_fail++;
                    $display("FAIL reseed_nogrant[%0d]: valid=%b gnt=%b, required 0 0000", j, bus.rnd_valid, bus.gnt);
                end
            end
            if (j >= 1) begin
                n_chk++;
                if (core_seed !== 64'h1 || busy !== (j <= 8)) begin
                    n_fail++;
                    $display("FAIL reseed_state[%0d]: seed=%h busy=%b, required seed=1 busy=%b", j, core_seed, busy, (j <= 8));
                end
                if (rise < 0 && core_rst === 1'b1) rise = j;
                if (first_v < 0 && bus.rnd_valid === 1'b1) first_v = j;
            end
            drive(4'b1111, (j == 0), 64'h1);
            @(negedge clk);
        end
        // core_rst goes high in cycle t+3; the first grant lands in the 8th cycle counting that one.
        n_chk++;
        if (rise != 3 || first_v != 10) begin
            n_fail++;
            $display("FAIL reseed_latency: core_rst rise=%0d first gnt=%0d, required 3 and 10", rise, first_v);
        end
    endtask

    task automatic test_double_reseed();
        logic [3:0]  eg;
        logic [63:0] ed;
        logic [63:0] want_seed;
        int          busy_n = 0;
        int          first_v = -1;
        for (int j = 0; j < 15; j++) begin
            if (exp_g_q.size() != 0) begin
                eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
                n_chk++;
                if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
                    n_fail++;
                    $display("FAIL dbl_word: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                             bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
                end
            end else begin
                n_chk++;
                if (bus.rnd_valid !== 1'b0 || bus.gnt !== 4'b0) begin
                    n_fail++;
                    $display("FAIL dbl_nogrant[%0d]: valid=%b gnt=%b, required 0 0000", j, bus.rnd_valid, bus.gnt);
                end
            end
            if (j >= 1) begin
                want_seed = (j >= 4) ? 64'h2 : 64'hA5A5_0000_1234_5678;
                n_chk++;
                if (core_seed !== want_seed || busy !== (j <= 11) ||
                    core_rst !== !(j == 1 || j == 2 || j == 4 || j == 5)) begin
                    n_fail++;
                    $display("FAIL dbl_state[%0d]: seed=%h busy=%b core_rst=%b, required seed=%h busy=%b core_rst=%b",
                             j, core_seed, busy, core_rst, want_seed, (j <= 11),
                             !(j == 1 || j == 2 || j == 4 || j == 5));
                end
                if (j >= 4 && busy === 1'b1) busy_n++;
                if (first_v < 0 && bus.rnd_valid === 1'b1) first_v = j;
            end
            if (j == 0)      drive(4'b1111, 1'b1, 64'hA5A5_0000_1234_5678);
            else if (j == 3) drive(4'b1111, 1'b1, 64'h2);
            else             drive(4'b1111, 1'b0, 64'h0);
            @(negedge clk);
        end
        n_chk++;
        if (busy_n != 8 || first_v != 13 || core_seed !== 64'h2) begin
            n_fail++;
            $display("FAIL dbl_window: busy cycles=%0d first gnt=%0d seed=%h, required 8, 13, 2",
                     busy_n, first_v, core_seed);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0]  eg;
        logic [63:0] ed;
        int          first_v = -1;
        eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
        n_chk++;
        if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
            n_fail++;
            $display("FAIL arst_pre: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                     bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0 || bus.rnd_valid !== 1'b0 || bus.rnd_out !== 64'h0 ||
            core_rst !== 1'b0 || core_seed !== SEED_DEF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_now: gnt=%b valid=%b rnd=%h core_rst=%b seed=%h busy=%b, required 0000 0 0 0 %h 1",
                     bus.gnt, bus.rnd_valid, bus.rnd_out, core_rst, core_seed, busy, SEED_DEF);
        end
        exp_g_q.delete(); exp_d_q.delete();
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        blk    = 8;
        ptr_m  = 0;
        seed_m = SEED_DEF;
        for (int j = 0; j < 11; j++) begin
            if (exp_g_q.size() != 0) begin
                eg = exp_g_q.pop_front(); ed = exp_d_q.pop_front();
                n_chk++;
                if (bus.rnd_valid !== 1'b1 || bus.gnt !== eg || bus.rnd_out !== ed) begin
                    n_fail++;
                    $display("FAIL arst_word: valid=%b gnt=%b rnd=%h, required valid=1 gnt=%b rnd=%h",
                             bus.rnd_valid, bus.gnt, bus.rnd_out, eg, ed);
                end
                if (first_v < 0) begin
                    first_v = j;
                    n_chk++;
                    if (bus.gnt !== 4'b0001) begin
                        n_fail++;
                        $display("FAIL arst_ptr: first gnt=%b, required 0001", bus.gnt);
                    end
                end
            end else begin
                n_chk++;
                if (bus.rnd_valid !== 1'b0 || core_seed !== seed_m) begin
                    n_fail++;
                    $display("FAIL arst_idle[%0d]: valid=%b seed=%h, required 0 %h", j, bus.rnd_valid, core_seed, seed_m);
                end
            end
            drive(4'b1111, 1'b0, 64'h0);
            @(negedge clk);
        end
        n_chk++;
        if (first_v != 9) begin
            n_fail++;
            $display("FAIL arst_latency: first gnt=%0d, required 9", first_v);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_and_wrap();
        test_reseed_during_req();
        test_double_reseed();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
